multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a store (valid only with mem_req)
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- illegal  out  1  sticky illegal-instruction flag
- state  out  4  current state encoding (debug)
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL be a Moore FSM: outputs depend on state only, except pc_write (on mem_ready in FETCH, on zero in BEQ) and ir_write (on mem_ready in FETCH).
REQ-004 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-005 Unlisted outputs SHALL be 0 in every state.
REQ-006 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=000, result_src=10. Holds while mem_ready=0. With mem_ready=1: ir_write=1, pc_write=1, next DECODE.
REQ-007 DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_control=000. Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
REQ-008 MEMADR: alu_src_a=10, alu_src_b=01, alu_control=000, imm_src=00 for lw, 01 for sw. Next MEMREAD for lw, MEMWRITE for sw.
REQ-009 MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then MEMWB.
REQ-010 MEMWB: result_src=01, reg_write=1. Next FETCH.
REQ-011 MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready, then FETCH.
REQ-012 EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01, imm_src=00. Both go to ALUWB.
REQ-013 ALU decode in EXECR/EXECI by funct3:
- 000: add, or sub when EXECR and funct7b5=1
- 010: slt
- 110: or
- 111: and
- any other funct3: go to TRAP instead of ALUWB, no register write
REQ-014 ALUWB: result_src=00, reg_write=1. Next FETCH.
REQ-015 BEQ: alu_src_a=10, alu_src_b=00, alu_control=001, result_src=00, pc_write=zero. Next FETCH.
REQ-016 JAL: alu_src_a=01, alu_src_b=10, alu_control=000, result_src=00, pc_write=1. Next ALUWB, which writes oldPC+4 to rd.
REQ-017 TRAP: illegal=1. State holds until reset.
REQ-018 Instruction latency with zero-wait memory (mem_ready=1 on first request cycle):
- lw 5 cycles
- sw, R/I-type 4 cycles
- beq 3 cycles
- jal 4 cycles
- each mem_ready=0 cycle adds one cycle

Reset
REQ-019 While rst=1, asynchronously: state=FETCH, illegal=0, and all outputs at FETCH Moore values (mem_req=1, ir_write=0, pc_write=0, reg_write=0).
REQ-020 Reset asserted mid-access SHALL abandon the access; no reg_write or pc_write pulse during or after reset.
REQ-021 After rst deasserts, the first rising edge evaluates FETCH normally.

Verification
REQ-022 add (0110011, f3=000, f7b5=0), mem_ready=1: states 0,1,6,8,0; alu_control=000 in EXECR; reg_write high exactly one cycle.
REQ-023 lw, mem_ready low 2 cycles in MEMREAD: states 0,1,2,3,3,3,4,0; adr_src=1 throughout MEMREAD.
REQ-024 beq: zero=1 gives pc_write=1 in BEQ with alu_control=001; zero=0 gives pc_write=0.
REQ-025 opcode 1110011 -> TRAP; illegal=1 held 20 cycles; rst pulse -> FETCH, illegal=0.
REQ-026 rst asserted during MEMWRITE wait: state=0 immediately, mem_write=0, no reg_write.
REQ-027 jal: states 0,1,10,8,0; pc_write=1 in JAL; reg_write=1 in ALUWB.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Control FSM for a multicycle RV32I-subset datapath (lw, sw, R-type, I-type
// ALU, beq, jal). Each instruction walks FETCH -> DECODE -> ... -> FETCH.
// Any unsupported opcode or ALU funct3 parks the machine in TRAP. It stays
// there, with the sticky illegal flag raised, until reset.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   opcode      instr[6:0] from the instruction register
//   funct3      instr[14:12]
//   funct7b5    instr[30], selects sub for R-type funct3=000
//   zero        ALU zero flag, used for the beq decision
//   mem_ready   memory completes the current access this cycle
//   mem_req     memory access request
//   mem_write   access is a store
//   adr_src     memory address select: 0=PC, 1=ALUOut
//   ir_write    load IR and oldPC
//   pc_write    load PC from the result bus
//   reg_write   register file write enable
//   alu_src_a   00=PC, 01=oldPC, 10=rs1
//   alu_src_b   00=rs2, 01=imm, 10=constant 4
//   alu_control 000 add, 001 sub, 010 and, 011 or, 101 slt
//   result_src  00=ALUOut, 01=mem data, 10=ALU result
//   imm_src     00 I, 01 S, 10 B, 11 J
//   illegal     sticky illegal-instruction flag
//   state       current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // Moore outputs, held in one register bank
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;

    // funct3 values the ALU decoder supports
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic use_sub);
        logic [2:0] op;
        op = 3'b000;
        case (f3)
            3'b000:  op = use_sub ? 3'b001 : 3'b000;
            3'b010:  op = 3'b101;
            3'b110:  op = 3'b011;
            3'b111:  op = 3'b010;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    // Moore output table. The instruction fields are stable for the whole
    // instruction (IR only reloads in FETCH), so evaluating them on entry
    // to a state gives the same value as evaluating them inside it.
    function automatic ctrl_t ctrl_for(input state_t s, input logic is_sw,
                                       input logic [2:0] f3, input logic f7b5);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            ST_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            ST_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = is_sw ? 2'b01 : 2'b00;
            end
            ST_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            ST_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            ST_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b00;
                c.alu_control = alu_decode(f3, f7b5);
            end
            ST_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.imm_src     = 2'b00;
                c.alu_control = alu_decode(f3, 1'b0);
            end
            ST_ALUWB: begin
                c.reg_write = 1'b1;
            end
            ST_BEQ: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
            end
            ST_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            ST_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH:    state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_R:         state_next = ST_EXECR;
                    OP_I:         state_next = ST_EXECI;
                    OP_BEQ:       state_next = ST_BEQ;
                    OP_JAL:       state_next = ST_JAL;
                    default:      state_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   state_next = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  state_next = mem_ready ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWRITE: state_next = mem_ready ? ST_FETCH : ST_MEMWRITE;
            ST_EXECR,
            ST_EXECI:    state_next = f3_legal(funct3) ? ST_ALUWB : ST_TRAP;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BEQ:      state_next = ST_FETCH;
            ST_JAL:      state_next = ST_ALUWB;
            ST_TRAP:     state_next = ST_TRAP;
            default:     state_next = ST_FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they line up with
    // state_reg without a combinational decode after the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            ctrl_reg  <= ctrl_for(ST_FETCH, 1'b0, 3'b000, 1'b0);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next, opcode == OP_SW, funct3, funct7b5);
        end
    end

    // The only input-dependent strobes. They are gated by rst so that an
    // access abandoned by reset never loads IR or PC.
    assign ir_write = !rst && (state_reg == ST_FETCH) && mem_ready;
    assign pc_write = !rst && (((state_reg == ST_FETCH) && mem_ready) ||
                               ((state_reg == ST_BEQ) && zero) ||
                               (state_reg == ST_JAL));

    assign mem_req     = ctrl_reg.mem_req;
    assign mem_write   = ctrl_reg.mem_write;
    assign adr_src     = ctrl_reg.adr_src;
    assign reg_write   = ctrl_reg.reg_write;
    assign alu_src_a   = ctrl_reg.alu_src_a;
    assign alu_src_b   = ctrl_reg.alu_src_b;
    assign alu_control = ctrl_reg.alu_control;
    assign result_src  = ctrl_reg.result_src;
    assign imm_src     = ctrl_reg.imm_src;
    assign illegal     = ctrl_reg.illegal;
    assign state       = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Randomized instruction stream for the multicycle control unit. For every
// instruction the driver plans the state walk from the instruction class and
// the chosen memory wait counts. It then pushes one expected output vector
// per cycle into a scoreboard queue. A monitor on the falling edge pops one
// entry per cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .imm_src(imm_src), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    // Instruction classes
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;

    // Output vector layout (MSB..LSB): state, mem_req, mem_write, adr_src,
    // ir_write, pc_write, reg_write, alu_src_a, alu_src_b, alu_control,
    // result_src, imm_src, illegal
    localparam logic [21:0] FULL_MASK = 22'h3F_FFFF;
    localparam logic [21:0] NO_ALU    = 22'h3F_FF1F;

    typedef struct {
        logic [21:0] exp;
        logic [21:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    logic [21:0] act;
    assign act = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_control, result_src, imm_src, illegal};

    // Expected outputs for a state, taken from the per-state output tables.
    function automatic logic [21:0] model(input int st, input bit mr, input bit z,
                                          input bit is_sw, input logic [2:0] ac_in,
                                          input bit in_rst);
        logic [3:0] s;
        bit mreq, mw, adr, irw, pcw, rw, il;
        logic [1:0] a, b, rs, im;
        logic [2:0] ac;
        s = st[3:0];
        {mreq, mw, adr, irw, pcw, rw, il} = '0;
        a = 2'b00; b = 2'b00; rs = 2'b00; im = 2'b00; ac = 3'b000;
        case (st)
            0:  begin mreq = 1; b = 2'b10; rs = 2'b10; if (!in_rst && mr) begin irw = 1; pcw = 1; end end
            1:  begin a = 2'b01; b = 2'b01; im = 2'b10; end
            2:  begin a = 2'b10; b = 2'b01; im = is_sw ? 2'b01 : 2'b00; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin mreq = 1; mw = 1; adr = 1; end
            6:  begin a = 2'b10; ac = ac_in; end
            7:  begin a = 2'b10; b = 2'b01; ac = ac_in; end
            8:  begin rw = 1; end
            9:  begin a = 2'b10; ac = 3'b001; pcw = z; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            11: begin il = 1; end
            default: ;
        endcase
        return {s, mreq, mw, adr, irw, pcw, rw, a, b, ac, rs, im, il};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input bit is_r, input bit f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit f3_ok(input logic [2:0] f3);
        return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
    endfunction

    function automatic bit op_known(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show during that
    // cycle, and advance to just after the next rising edge.
    task automatic step(input int st, input bit mr, input bit z, input bit is_sw,
                        input logic [2:0] ac, input bit alu_dc, input bit in_rst,
                        input string lbl);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        rst       = in_rst;
        e.exp  = model(st, mr, z, is_sw, ac, in_rst);
        e.mask = alu_dc ? NO_ALU : FULL_MASK;
        e.name = $sformatf("%s st%0d", lbl, st);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string lbl);
        step(0, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 1, lbl);
    endtask

    task automatic trap_hold(input int n, input string lbl);
        for (int i = 0; i < n; i++)
            step(11, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
        reset_cycle({lbl, "_rst"});
    endtask

    // zsel: -1 random zero in BEQ, else forced; abort: -1 none, else number
    // of MEMWRITE wait cycles before reset hits.
    task automatic run_instr(input int kind, input logic [6:0] bad_op,
                             input logic [2:0] f3, input bit f7,
                             input int wf, input int wm, input int zsel,
                             input int abort, input int hold);
        string      lbl;
        logic [2:0] ac;
        bit         z;
        case (kind)
            K_LW:    begin opcode = 7'b0000011; lbl = "lw";  end
            K_SW:    begin opcode = 7'b0100011; lbl = "sw";  end
            K_R:     begin opcode = 7'b0110011; lbl = "rtype"; end
            K_I:     begin opcode = 7'b0010011; lbl = "itype"; end
            K_BEQ:   begin opcode = 7'b1100011; lbl = "beq"; end
            K_JAL:   begin opcode = 7'b1101111; lbl = "jal"; end
            default: begin opcode = bad_op;     lbl = "badop"; end
        endcase
        funct3   = f3;
        funct7b5 = f7;
        for (int i = 0; i < wf; i++) step(0, 0, 1'($urandom), 0, 3'b000, 0, 0, lbl);
        step(0, 1, 1'($urandom), 0, 3'b000, 0, 0, lbl);
        step(1, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
        case (kind)
            K_LW: begin
                step(2, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
                for (int i = 0; i < wm; i++) step(3, 0, 1'($urandom), 0, 3'b000, 0, 0, lbl);
                step(3, 1, 1'($urandom), 0, 3'b000, 0, 0, lbl);
                step(4, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
            end
            K_SW: begin
                step(2, 1'($urandom), 1'($urandom), 1, 3'b000, 0, 0, lbl);
                if (abort >= 0) begin
                    for (int i = 0; i < abort; i++) step(5, 0, 1'($urandom), 0, 3'b000, 0, 0, lbl);
                    reset_cycle("sw_abort_rst");
                end else begin
                    for (int i = 0; i < wm; i++) step(5, 0, 1'($urandom), 0, 3'b000, 0, 0, lbl);
                    step(5, 1, 1'($urandom), 0, 3'b000, 0, 0, lbl);
                end
            end
            K_R, K_I: begin
                ac = exp_alu(f3, kind == K_R, f7);
                step(kind == K_R ? 6 : 7, 1'($urandom), 1'($urandom), 0, ac, !f3_ok(f3), 0, lbl);
                if (f3_ok(f3)) step(8, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
                else           trap_hold(hold, "badf3");
            end
            K_BEQ: begin
                z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
                step(9, 1'($urandom), z, 0, 3'b000, 0, 0, lbl);
            end
            K_JAL: begin
                step(10, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
                step(8, 1'($urandom), 1'($urandom), 0, 3'b000, 0, 0, lbl);
            end
            default: trap_hold(hold, lbl);
        endcase
    endtask

    // Scoreboard monitor: one expected vector per cycle
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL underflow: got %h, required a queued expectation", act);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    fails++;
                    $display("FAIL %s: got %h required %h (mask %h)", e.name, act, e.exp, e.mask);
                end
            end
        end
    end

    initial begin
        logic [6:0] bop;
        logic [2:0] f3;
        int         r, kind;
        rst = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset_cycle("por");
        reset_cycle("por");

        // Directed scenarios
        run_instr(K_R,   7'h00, 3'b000, 1'b0, 0, 0, -1, -1, 0);   // add
        run_instr(K_R,   7'h00, 3'b000, 1'b1, 1, 0, -1, -1, 0);   // sub
        run_instr(K_LW,  7'h00, 3'b010, 1'b0, 0, 2, -1, -1, 0);   // lw, 2 waits
        run_instr(K_BEQ, 7'h00, 3'b000, 1'b0, 0, 0, 1, -1, 0);    // taken
        run_instr(K_BEQ, 7'h00, 3'b000, 1'b0, 0, 0, 0, -1, 0);    // not taken
        run_instr(K_JAL, 7'h00, 3'b000, 1'b0, 0, 0, -1, -1, 0);
        run_instr(K_SW,  7'h00, 3'b010, 1'b0, 0, 0, -1, -1, 0);
        run_instr(K_BAD, 7'b1110011, 3'b000, 1'b0, 0, 0, -1, -1, 20);
        run_instr(K_SW,  7'h00, 3'b010, 1'b0, 0, 0, -1, 2, 0);    // reset in MEMWRITE wait
        run_instr(K_I,   7'h00, 3'b001, 1'b0, 0, 0, -1, -1, 3);   // unsupported funct3

        // Random stream
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            kind = (r < 15) ? K_LW : (r < 30) ? K_SW : (r < 50) ? K_R :
                   (r < 70) ? K_I  : (r < 82) ? K_BEQ : (r < 93) ? K_JAL : K_BAD;
            do bop = 7'($urandom); while (op_known(bop));
            f3 = 3'($urandom);
            if ((kind == K_R || kind == K_I) && $urandom_range(0, 99) < 85)
                while (!f3_ok(f3)) f3 = 3'($urandom);
            run_instr(kind, bop, f3, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      -1,
                      (kind == K_SW && $urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1,
                      $urandom_range(1, 20));
        end

        mon_en = 1'b0;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d queued entries, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
